// File: rtl/led_frame_buffer.sv
// Double-buffered frame store feeding the 8x8 LED scan controller.
// Host rows land in a back buffer; a commit copies the back buffer into the
// front buffer (frame_out) only on the last row pulse of a scan frame, so the
// display never shows a partially written frame. Also owns the scan tick
// divider that paces the controller's row stepping.
module led_frame_buffer #(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_data,
  input  logic        clr,
  input  logic        commit,
  output logic [63:0] frame_out,
  output logic        time_pulse,
  output logic        pending,
  output logic        commit_ack,
  output logic        wr_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pulse_idx_q, pulse_idx_d;
  logic [63:0]      back_q, back_d;
  logic [63:0]      front_q, front_d;
  logic             pend_q, pend_d;
  logic             tp_q, tp_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             boundary;
  logic [5:0]       row_lsb;

  // Next-state logic: tick divider, back buffer edits, commit and swap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    tp_d  = 1'b0;
    if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      cnt_d = '0;
      tp_d  = 1'b1;
    end

    pulse_idx_d = tp_q ? pulse_idx_q + 3'd1 : pulse_idx_q;
    boundary    = tp_q && (pulse_idx_q == 3'd7);

    // Row 0 is the top row and sits in the most significant byte.
    row_lsb = {~wr_row, 3'b000};

    back_d = back_q;
    err_d  = 1'b0;
    if (pend_q) begin
      // Back buffer is frozen until the pending copy has been taken.
      err_d = wr_en || clr;
    end else if (clr) begin
      back_d = '0;
    end else if (wr_en) begin
      back_d[row_lsb +: 8] = wr_data;
    end

    pend_d  = pend_q;
    front_d = front_q;
    ack_d   = 1'b0;
    if (pend_q) begin
      if (boundary) begin
        front_d = back_q;
        pend_d  = 1'b0;
        ack_d   = 1'b1;
      end
    end else if (commit) begin
      // A commit arriving on a boundary pulse waits for the next boundary,
      // since pend_q is still low while this boundary is evaluated.
      pend_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      pulse_idx_q <= '0;
      back_q      <= '0;
      front_q     <= '0;
      pend_q      <= 1'b0;
      tp_q        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pulse_idx_q <= pulse_idx_d;
      back_q      <= back_d;
      front_q     <= front_d;
      pend_q      <= pend_d;
      tp_q        <= tp_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign frame_out  = front_q;
  assign time_pulse = tp_q;
  assign pending    = pend_q;
  assign commit_ack = ack_q;
  assign wr_err     = err_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer with TICK_DIV=4.
// Stimulus pushes expected commit_ack / wr_err / time_pulse events; an
// independent monitor pops and compares whenever the DUT presents one.
module tb_led_frame_buffer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [7:0]  wr_data = '0;
  logic        clr = 1'b0;
  logic        commit = 1'b0;
  logic [63:0] frame_out;
  logic        time_pulse;
  logic        pending;
  logic        commit_ack;
  logic        wr_err;

  led_frame_buffer #(.TICK_DIV(TD), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clr(clr), .commit(commit), .frame_out(frame_out), .time_pulse(time_pulse),
    .pending(pending), .commit_ack(commit_ack), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Cycle number: count of clock edges since the last reset edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [63:0] frame;
  } ack_t;

  ack_t ack_q[$];
  int   err_q[$];
  int   pulse_q[$];
  bit   chk_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event at cycle %0d expected none", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      step();
      guard++;
    end
    if (cyc < n) begin
      checks++;
      errors++;
      $display("FAIL run_until: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    check("rst_frame", frame_out, 64'h0);
    check("rst_pending", {63'h0, pending}, 64'h0);
    check("rst_ack", {63'h0, commit_ack}, 64'h0);
    check("rst_err", {63'h0, wr_err}, 64'h0);
    check("rst_pulse", {63'h0, time_pulse}, 64'h0);
    rst = 1'b1;
  endtask

  // Monitor: compare every output event against the scoreboard queues.
  initial begin
    forever begin
      ack_t e;
      int   c;
      @(negedge clk);
      if (commit_ack === 1'b1) begin
        if (ack_q.size() == 0) unexpected("unexpected_ack");
        else begin
          e = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(e.cyc));
          check("ack_frame", frame_out, e.frame);
        end
      end
      if (wr_err === 1'b1) begin
        if (err_q.size() == 0) unexpected("unexpected_wr_err");
        else begin
          c = err_q.pop_front();
          check("wr_err_cycle", 64'(cyc), 64'(c));
        end
      end
      if (chk_pulse && time_pulse === 1'b1) begin
        if (pulse_q.size() == 0) unexpected("unexpected_pulse");
        else begin
          c = pulse_q.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Idle after reset: pulses every TD cycles, nothing else moves.
    do_reset();
    for (int k = 1; k <= 10; k++) pulse_q.push_back(k * TD);
    chk_pulse = 1'b1;
    run_until(40);
    step();
    chk_pulse = 1'b0;
    check("idle_pulses_left", 64'(pulse_q.size()), 64'h0);
    check("idle_frame", frame_out, 64'h0);
    check("idle_pending", {63'h0, pending}, 64'h0);

    // Full frame write, commit, rejected write while pending.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      wr_en = 1'b1;
      wr_row = 3'(r);
      wr_data = 8'd1 << r;
      step();
    end
    wr_en = 1'b0;
    run_until(9);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("commit_pending", {63'h0, pending}, 64'h1);
    ack_q.push_back('{cyc: 33, frame: 64'h0102040810204080});
    wr_en = 1'b1;
    wr_row = 3'd3;
    wr_data = 8'hFF;
    err_q.push_back(11);
    step();
    wr_en = 1'b0;
    run_until(15);
    commit = 1'b1;
    step();
    commit = 1'b0;
    run_until(40);
    check("frame_after_swap", frame_out, 64'h0102040810204080);
    check("row3_kept", {56'h0, frame_out[39:32]}, 64'h08);
    check("pending_cleared", {63'h0, pending}, 64'h0);

    // clr beats a same-cycle write; committed frame is all zero.
    clr = 1'b1;
    wr_en = 1'b1;
    wr_row = 3'd0;
    wr_data = 8'hAA;
    step();
    clr = 1'b0;
    wr_en = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("clr_commit_pending", {63'h0, pending}, 64'h1);
    ack_q.push_back('{cyc: 65, frame: 64'h0});
    run_until(70);
    check("frame_after_clr", frame_out, 64'h0);

    // Commit on a boundary pulse defers to the following boundary.
    run_until(80);
    wr_en = 1'b1;
    wr_row = 3'd7;
    wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    run_until(96);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("boundary_commit_pending", {63'h0, pending}, 64'h1);
    check("boundary_no_swap", frame_out, 64'h0);
    ack_q.push_back('{cyc: 129, frame: 64'h5A});
    run_until(135);
    check("deferred_frame", frame_out, 64'h5A);

    // One-cycle reset while pending discards the request.
    run_until(140);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("pre_reset_pending", {63'h0, pending}, 64'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_pending", {63'h0, pending}, 64'h0);
    check("mid_rst_frame", frame_out, 64'h0);
    check("mid_rst_pulse", {63'h0, time_pulse}, 64'h0);
    pulse_q.push_back(TD);
    pulse_q.push_back(2 * TD);
    chk_pulse = 1'b1;
    run_until(2 * TD);
    step();
    chk_pulse = 1'b0;
    check("restart_pulses_left", 64'(pulse_q.size()), 64'h0);
    run_until(40);
    check("discarded_frame", frame_out, 64'h0);
    check("discarded_pending", {63'h0, pending}, 64'h0);

    check("acks_left", 64'(ack_q.size()), 64'h0);
    check("errs_left", 64'(err_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
